// File: rtl/dds_sweep_pkg.sv
// dds_sweep_pkg: shared state encoding and widths for the DDS frequency sweeper.
package dds_sweep_pkg;
    localparam int FREQ_W           = 24;
    localparam int PERIOD_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DWELL_HI,
        S_DOWN,
        S_DWELL_LO
    } state_t;
endpackage

// File: rtl/dds_sweep_timer.sv
// dds_sweep_timer: reloadable down-counter timing the step period and end-point dwell.
module dds_sweep_timer
    import dds_sweep_pkg::*;
#(
    parameter int W = PERIOD_W_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);
    logic [W-1:0] r_count;

    // Loading N gives N+1 clocks until the next expiry-driven reload.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign o_expired = (r_count == '0);
endmodule

// File: rtl/dds_sweep.sv
// dds_sweep: tuning-word sweep generator (single up-sweep or continuous up/down)
// feeding a DDS Frequency/Sync interface.
module dds_sweep
    import dds_sweep_pkg::*;
#(
    parameter int PERIOD_WIDTH = PERIOD_W_DEFAULT
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [FREQ_W-1:0]       Start_Freq,
    input  logic [FREQ_W-1:0]       Stop_Freq,
    input  logic [FREQ_W-1:0]       Step,
    input  logic [PERIOD_WIDTH-1:0] Step_Period,
    input  logic [PERIOD_WIDTH-1:0] Dwell,
    input  logic                    Mode,
    input  logic                    Start,
    input  logic                    Abort,
    output logic [FREQ_W-1:0]       Frequency,
    output logic                    Sync,
    output logic                    Busy,
    output logic                    Done
);
    state_t                  r_state, w_next;
    logic [FREQ_W-1:0]       r_freq, w_freq;
    logic                    r_sync, w_sync, r_done, w_done;
    logic [FREQ_W-1:0]       r_start, r_stop, r_step;
    logic [PERIOD_WIDTH-1:0] r_period, r_dwell, w_load_val;
    logic                    r_mode, w_load, w_expired, w_top, w_bot;
    logic [FREQ_W:0]         w_sum, w_diff;

    dds_sweep_timer #(.W(PERIOD_WIDTH)) u_timer (
        .i_clk     (Clk),
        .i_rst     (Reset),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .o_expired (w_expired)
    );

    // One spare bit catches overflow past 2^24 and underflow below zero.
    assign w_sum  = {1'b0, r_freq} + {1'b0, r_step};
    assign w_diff = {1'b0, r_freq} - {1'b0, r_step};
    assign w_top  = w_sum >= {1'b0, r_stop};
    assign w_bot  = w_diff[FREQ_W] || (w_diff[FREQ_W-1:0] <= r_start);

    always_comb begin
        w_next     = r_state;
        w_freq     = r_freq;
        w_load     = 1'b0;
        w_load_val = r_period;
        w_sync     = 1'b0;
        w_done     = 1'b0;
        if (Abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (Start) begin
                    w_sync     = 1'b1;
                    w_freq     = Start_Freq;
                    w_load     = 1'b1;
                    w_next     = (Stop_Freq <= Start_Freq) ? S_DWELL_HI : S_UP;
                    w_load_val = (Stop_Freq <= Start_Freq) ? Dwell : Step_Period;
                end
                S_UP: if (w_expired) begin
                    w_load     = 1'b1;
                    w_next     = w_top ? S_DWELL_HI : S_UP;
                    w_freq     = w_top ? r_stop : w_sum[FREQ_W-1:0];
                    w_load_val = w_top ? r_dwell : r_period;
                end
                S_DWELL_HI: if (w_expired) begin
                    w_load = r_mode;
                    w_next = r_mode ? S_DOWN : S_IDLE;
                    w_done = !r_mode;
                end
                S_DOWN: if (w_expired) begin
                    w_load     = 1'b1;
                    w_next     = w_bot ? S_DWELL_LO : S_DOWN;
                    w_freq     = w_bot ? r_start : w_diff[FREQ_W-1:0];
                    w_load_val = w_bot ? r_dwell : r_period;
                end
                S_DWELL_LO: if (w_expired) begin
                    w_load = 1'b1;
                    w_next = S_UP;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_freq  <= '0;
            r_sync  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_freq  <= w_freq;
            r_sync  <= w_sync;
            r_done  <= w_done;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_start  <= '0;
            r_stop   <= '0;
            r_step   <= '0;
            r_period <= '0;
            r_dwell  <= '0;
            r_mode   <= 1'b0;
        end else if (r_state == S_IDLE && Start && !Abort) begin
            r_start  <= Start_Freq;
            r_stop   <= Stop_Freq;
            r_step   <= (Step == '0) ? FREQ_W'(1) : Step;
            r_period <= Step_Period;
            r_dwell  <= Dwell;
            r_mode   <= Mode;
        end
    end

    assign Frequency = r_freq;
    assign Sync      = r_sync;
    assign Busy      = (r_state != S_IDLE);
    assign Done      = r_done;
endmodule
